// File: rtl/cdb_arbiter_pkg.sv
// Shared types and helpers for the common data bus arbiter: ROB tag and
// broadcast packet layout, default sizing, and the ROB age computation.
package cdb_arbiter_pkg;

    localparam int NUM_FU    = 4;
    localparam int ROB_SZ    = 8;
    localparam int ROB_TAG_W = $clog2(ROB_SZ + 1);
    localparam int AGE_W     = ROB_TAG_W + 1;

    typedef logic [ROB_TAG_W-1:0] ROB_TAG;

    typedef struct packed {
        ROB_TAG      rob_tag;
        logic [31:0] v;
        logic        branch_mispredicted;
        logic [31:0] branch_loc;
    } CDB_ROB_PACKET;

    // Distance of a tag from the ROB head, in [0, sz). One extra bit keeps
    // tag + sz from overflowing before the single conditional wrap.
    function automatic logic [AGE_W-1:0] rob_age(input ROB_TAG tag, input ROB_TAG head, input int sz);
        logic [AGE_W-1:0] sum;
        sum = {1'b0, tag} + AGE_W'(sz) - {1'b0, head};
        if (sum >= AGE_W'(sz)) begin
            sum = sum - AGE_W'(sz);
        end
        return sum;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Generic round-robin picker: returns a one-hot grant for the first
// requester found when scanning upward from ptr, wrapping at N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    // Scan from the pointer and stop at the first active request
    always_comb begin
        int   idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx[PTR_W-1:0]]) begin
                grant[idx[PTR_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, a
// round-robin grant among live slots, and a registered single-packet
// broadcast per cycle. Mispredict squashes drop younger work by ROB age.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = cdb_arbiter_pkg::NUM_FU,
    parameter int ROB_SZ = cdb_arbiter_pkg::ROB_SZ
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_FU-1:0]             fu_valid,
    input  CDB_ROB_PACKET [NUM_FU-1:0]    fu_packet,
    output logic [NUM_FU-1:0]             fu_ready,
    input  ROB_TAG                        rob_head_tag,
    input  logic                          squash_valid,
    input  ROB_TAG                        squash_tag,
    output CDB_ROB_PACKET                 cdb_rob_packet,
    output logic [$clog2(NUM_FU+1)-1:0]   pending_cnt
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_W = $clog2(NUM_FU + 1);

    logic [NUM_FU-1:0]          slot_valid;
    CDB_ROB_PACKET [NUM_FU-1:0] slot_packet;
    logic [PTR_W-1:0]           rr_ptr;

    logic [NUM_FU-1:0]          slot_squashed;
    logic [NUM_FU-1:0]          incoming_squashed;
    logic [NUM_FU-1:0]          eligible;
    logic [NUM_FU-1:0]          grant;
    logic [NUM_FU-1:0]          capture;
    logic [AGE_W-1:0]           squash_age;
    CDB_ROB_PACKET              grant_packet;
    logic                       grant_any;
    logic [PTR_W-1:0]           next_ptr;

    // Anything strictly younger than the mispredicted branch is squashed
    always_comb begin
        squash_age        = rob_age(squash_tag, rob_head_tag, ROB_SZ);
        slot_squashed     = '0;
        incoming_squashed = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (squash_valid) begin
                slot_squashed[i]     = slot_valid[i] &&
                    (rob_age(slot_packet[i].rob_tag, rob_head_tag, ROB_SZ) > squash_age);
                incoming_squashed[i] =
                    (rob_age(fu_packet[i].rob_tag, rob_head_tag, ROB_SZ) > squash_age);
            end
        end
    end

    assign eligible = slot_valid & ~slot_squashed;

    rr_arbiter #(
        .N     (NUM_FU),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // A slot can take new work when empty or when it drains this edge
    assign fu_ready = ~slot_valid | grant;

    // Accept a request only with a real tag that is not being squashed
    always_comb begin
        capture = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            capture[i] = fu_valid[i] && fu_ready[i] &&
                         (fu_packet[i].rob_tag != '0) && !incoming_squashed[i];
        end
    end

    // Select the granted slot's packet and the pointer just past it
    always_comb begin
        grant_packet = '0;
        next_ptr     = rr_ptr;
        grant_any    = |grant;
        for (int i = 0; i < NUM_FU; i++) begin
            if (grant[i]) begin
                grant_packet = slot_packet[i];
                next_ptr     = (i == NUM_FU - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // Occupancy count of the holding slots
    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            pending_cnt = pending_cnt + CNT_W'(slot_valid[i]);
        end
    end

    // Slot storage: refill wins over drain so a granted slot can reload
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_valid  <= '0;
            slot_packet <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (capture[i]) begin
                    slot_valid[i]  <= 1'b1;
                    slot_packet[i] <= fu_packet[i];
                end else if (grant[i] || slot_squashed[i]) begin
                    slot_valid[i]  <= 1'b0;
                end
            end
        end
    end

    // Registered broadcast (all zeros when idle) and round-robin pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cdb_rob_packet <= '0;
            rr_ptr         <= '0;
        end else begin
            cdb_rob_packet <= grant_packet;
            if (grant_any) begin
                rr_ptr <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a slot-level reference model compared
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NFU = 4;
    localparam int RSZ = 8;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [NFU-1:0]           fu_valid;
    CDB_ROB_PACKET [NFU-1:0]  fu_packet;
    logic [NFU-1:0]           fu_ready;
    ROB_TAG                   rob_head_tag;
    logic                     squash_valid;
    ROB_TAG                   squash_tag;
    CDB_ROB_PACKET            cdb_rob_packet;
    logic [2:0]               pending_cnt;

    int n_vectors     = 0;
    int n_miscompares = 0;
    bit cmp_en        = 0;

    bit            m_valid [NFU];
    CDB_ROB_PACKET m_pkt   [NFU];
    int            m_ptr = 0;
    CDB_ROB_PACKET m_cdb = '0;

    always #5 clock = ~clock;

    cdb_arbiter #(
        .NUM_FU (NFU),
        .ROB_SZ (RSZ)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .fu_valid       (fu_valid),
        .fu_packet      (fu_packet),
        .fu_ready       (fu_ready),
        .rob_head_tag   (rob_head_tag),
        .squash_valid   (squash_valid),
        .squash_tag     (squash_tag),
        .cdb_rob_packet (cdb_rob_packet),
        .pending_cnt    (pending_cnt)
    );

    function automatic CDB_ROB_PACKET make_pkt(input int tag);
        CDB_ROB_PACKET p;
        p.rob_tag             = ROB_TAG'(tag);
        p.v                   = 32'h56 ^ 32'(tag);
        p.branch_mispredicted = tag[0];
        p.branch_loc          = 32'h1000 + 32'(tag * 4);
        return p;
    endfunction

    function automatic int m_age(input int t);
        return (t - int'(rob_head_tag) + RSZ) % RSZ;
    endfunction

    function automatic bit m_squashed(input int t);
        return squash_valid && (m_age(t) > m_age(int'(squash_tag)));
    endfunction

    function automatic int m_pick();
        for (int k = 0; k < NFU; k++) begin
            int i;
            i = (m_ptr + k) % NFU;
            if (m_valid[i] && !m_squashed(int'(m_pkt[i].rob_tag))) return i;
        end
        return -1;
    endfunction

    function automatic int m_count();
        int c;
        c = 0;
        for (int i = 0; i < NFU; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: one broadcast per edge chosen round-robin among live slots
    always @(posedge clock or posedge reset) begin
        int            g;
        bit            rdy [NFU];
        CDB_ROB_PACKET old [NFU];
        if (reset) begin
            for (int i = 0; i < NFU; i++) m_valid[i] = 0;
            m_ptr = 0;
            m_cdb = '0;
        end else begin
            g = m_pick();
            for (int i = 0; i < NFU; i++) begin
                rdy[i] = !m_valid[i] || (g == i);
                old[i] = m_pkt[i];
            end
            for (int i = 0; i < NFU; i++) begin
                if (fu_valid[i] && rdy[i] && fu_packet[i].rob_tag != 0 &&
                    !m_squashed(int'(fu_packet[i].rob_tag))) begin
                    m_valid[i] = 1;
                    m_pkt[i]   = fu_packet[i];
                end else if (g == i || (m_valid[i] && m_squashed(int'(m_pkt[i].rob_tag)))) begin
                    m_valid[i] = 0;
                end
            end
            if (g >= 0) begin
                m_cdb = old[g];
                m_ptr = (g + 1) % NFU;
            end else begin
                m_cdb = '0;
            end
        end
    end

    // Compare DUT outputs against the model mid-cycle
    always @(negedge clock) begin
        int             g;
        logic [NFU-1:0] exp_ready;
        if (cmp_en) begin
            g = m_pick();
            for (int i = 0; i < NFU; i++) exp_ready[i] = !m_valid[i] || (g == i);
            check_output("model_cdb", 128'(cdb_rob_packet), 128'(m_cdb));
            check_output("model_pending", 128'(pending_cnt), 128'(m_count()));
            check_output("model_ready", 128'(fu_ready), 128'(exp_ready));
        end
    end

    task automatic set_inputs(input logic [NFU-1:0] valid, input int t0, input int t1, input int t2, input int t3);
        fu_valid     = valid;
        fu_packet[0] = make_pkt(t0);
        fu_packet[1] = make_pkt(t1);
        fu_packet[2] = make_pkt(t2);
        fu_packet[3] = make_pkt(t3);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic [NFU-1:0] valid, input int t0, input int t1, input int t2, input int t3);
        set_inputs(valid, t0, t1, t2, t3);
        tick();
    endtask

    task automatic do_reset();
        set_inputs('0, 0, 0, 0, 0);
        squash_valid = 0;
        squash_tag   = '0;
        rob_head_tag = ROB_TAG'(1);
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    int exp_fair [9] = '{0, 5, 6, 5, 6, 5, 6, 5, 6};

    initial begin
        reset        = 1;
        fu_valid     = '0;
        fu_packet    = '0;
        rob_head_tag = ROB_TAG'(1);
        squash_valid = 0;
        squash_tag   = '0;
        for (int i = 0; i < NFU; i++) begin
            m_valid[i] = 0;
            m_pkt[i]   = '0;
        end
        tick();
        tick();
        reset  = 0;
        cmp_en = 1;

        check_output("reset_pending", 128'(pending_cnt), 128'(0));
        check_output("reset_cdb", 128'(cdb_rob_packet), 128'(0));
        check_output("reset_ready", 128'(fu_ready), 128'(4'hF));

        // Single request, plus a tag-0 request that must be ignored
        apply_stimulus(4'b0011, 3, 0, 0, 0);
        check_output("single_pending", 128'(pending_cnt), 128'(1));
        check_output("single_cdb_early", 128'(cdb_rob_packet.rob_tag), 128'(0));
        apply_stimulus('0, 0, 0, 0, 0);
        check_output("single_cdb_tag", 128'(cdb_rob_packet.rob_tag), 128'(3));
        check_output("single_cdb_v", 128'(cdb_rob_packet.v), 128'(32'h55));
        check_output("single_pending_drained", 128'(pending_cnt), 128'(0));
        apply_stimulus('0, 0, 0, 0, 0);
        check_output("single_cdb_after", 128'(cdb_rob_packet.rob_tag), 128'(0));

        // Four-way contention from pointer 0
        do_reset();
        apply_stimulus(4'hF, 1, 2, 3, 4);
        check_output("contend_pending_full", 128'(pending_cnt), 128'(4));
        for (int k = 0; k < 4; k++) begin
            apply_stimulus('0, 0, 0, 0, 0);
            check_output($sformatf("contend_tag_%0d", k), 128'(cdb_rob_packet.rob_tag), 128'(k + 1));
            check_output($sformatf("contend_pending_%0d", k), 128'(pending_cnt), 128'(3 - k));
        end

        // Fairness: FU0 and FU1 continuously requesting
        do_reset();
        for (int k = 0; k < 9; k++) begin
            if (k < 7) apply_stimulus(4'b0011, 5, 6, 0, 0);
            else       apply_stimulus('0, 0, 0, 0, 0);
            check_output($sformatf("fair_tag_%0d", k), 128'(cdb_rob_packet.rob_tag), 128'(exp_fair[k]));
        end
        check_output("fair_pending_drained", 128'(pending_cnt), 128'(0));

        // Squash with wrap-around: head 7, slots hold 8,1,2, squash at 8
        do_reset();
        rob_head_tag = ROB_TAG'(7);
        apply_stimulus(4'b0111, 8, 1, 2, 0);
        check_output("squash_pending_before", 128'(pending_cnt), 128'(3));
        squash_valid = 1;
        squash_tag   = ROB_TAG'(8);
        set_inputs(4'b1000, 0, 0, 0, 1);
        #1;
        check_output("squash_ready", 128'(fu_ready), 128'(4'b1001));
        tick();
        squash_valid = 0;
        check_output("squash_cdb_tag", 128'(cdb_rob_packet.rob_tag), 128'(8));
        check_output("squash_pending_after", 128'(pending_cnt), 128'(0));
        for (int k = 0; k < 3; k++) begin
            apply_stimulus('0, 0, 0, 0, 0);
            check_output($sformatf("squash_quiet_%0d", k), 128'(cdb_rob_packet.rob_tag), 128'(0));
        end

        // Grant and refill of FU2 on the same edge
        do_reset();
        apply_stimulus(4'b0100, 0, 0, 3, 0);
        check_output("refill_pending_first", 128'(pending_cnt), 128'(1));
        set_inputs(4'b0100, 0, 0, 5, 0);
        #1;
        check_output("refill_ready2", 128'(fu_ready[2]), 128'(1));
        tick();
        check_output("refill_cdb_old", 128'(cdb_rob_packet.rob_tag), 128'(3));
        check_output("refill_pending_held", 128'(pending_cnt), 128'(1));
        apply_stimulus('0, 0, 0, 0, 0);
        check_output("refill_cdb_new", 128'(cdb_rob_packet.rob_tag), 128'(5));
        check_output("refill_pending_done", 128'(pending_cnt), 128'(0));

        // Reset mid-operation with three slots pending
        apply_stimulus(4'b1011, 7, 6, 0, 4);
        check_output("midreset_pending_before", 128'(pending_cnt), 128'(3));
        set_inputs('0, 0, 0, 0, 0);
        #2;
        reset = 1;
        #1;
        check_output("midreset_cdb", 128'(cdb_rob_packet.rob_tag), 128'(0));
        check_output("midreset_pending", 128'(pending_cnt), 128'(0));
        check_output("midreset_ready", 128'(fu_ready), 128'(4'hF));
        tick();
        tick();
        reset = 0;
        for (int k = 0; k < 4; k++) begin
            apply_stimulus('0, 0, 0, 0, 0);
            check_output($sformatf("midreset_quiet_%0d", k), 128'(cdb_rob_packet.rob_tag), 128'(0));
        end

        cmp_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
